// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor holding mtime, mtimecmp and msip behind a single-cycle bus slave.
module clint_timer #(
    parameter int ADDR_WIDTH = 16,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  irq_timer_o,
    output logic                  irq_software_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_MSIP  = ADDR_WIDTH'(32'h0000);
    localparam logic [ADDR_WIDTH-1:0] A_CMPLO = ADDR_WIDTH'(32'h4000);
    localparam logic [ADDR_WIDTH-1:0] A_CMPHI = ADDR_WIDTH'(32'h4004);
    localparam logic [ADDR_WIDTH-1:0] A_MTLO  = ADDR_WIDTH'(32'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] A_MTHI  = ADDR_WIDTH'(32'hBFFC);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d, mtime_inc;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          irq_timer_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rdata_d, rd_val;
    logic          err_q;
    logic          tick, hit, wr;

    assign tick = presc_q == PW'(TICK_DIV - 1);
    assign hit  = addr_i inside {A_MSIP, A_CMPLO, A_CMPHI, A_MTLO, A_MTHI};
    assign wr   = req_i & we_i;
    assign mtime_inc = mtime_q + {63'b0, tick};

    // Misaligned offsets never match a mapped word address, so they fall out as errors.
    assign rd_val = (addr_i == A_MSIP)  ? {31'b0, msip_q}     :
                    (addr_i == A_CMPLO) ? mtimecmp_q[31:0]    :
                    (addr_i == A_CMPHI) ? mtimecmp_q[63:32]   :
                    (addr_i == A_MTLO)  ? mtime_q[31:0]       :
                    (addr_i == A_MTHI)  ? mtime_q[63:32]      : 32'b0;

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = (wr && addr_i == A_MTLO) ? {mtime_inc[63:32], wdata_i} :
                     (wr && addr_i == A_MTHI) ? {wdata_i, mtime_inc[31:0]} : mtime_inc;
        mtimecmp_d = (wr && addr_i == A_CMPLO) ? {mtimecmp_q[63:32], wdata_i} :
                     (wr && addr_i == A_CMPHI) ? {wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
        msip_d     = (wr && addr_i == A_MSIP) ? wdata_i[0] : msip_q;
        rdata_d    = (req_i && !we_i && hit) ? rd_val : 32'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            irq_timer_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            irq_timer_q <= mtime_q >= mtimecmp_q;
            rvalid_q    <= req_i;
            rdata_q     <= rdata_d;
            err_q       <= req_i & ~hit;
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign err_o          = err_q;
    assign irq_timer_o    = irq_timer_q;
    assign irq_software_o = msip_q;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: drives two clint_timer instances (TICK_DIV 1 and 4) from one bus and checks
// them against a cycle-count based reference model plus directed constant expectations.
module tb_clint_timer;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rv[2];
    logic [31:0] rdat[2];
    logic        er[2];
    logic        irqt[2];
    logic        irqs[2];

    int checks = 0;
    int failures = 0;

    clint_timer #(.ADDR_WIDTH(16), .TICK_DIV(1)) dut1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rvalid_o(rv[0]), .rdata_o(rdat[0]), .err_o(er[0]),
        .irq_timer_o(irqt[0]), .irq_software_o(irqs[0]));
    clint_timer #(.ADDR_WIDTH(16), .TICK_DIV(4)) dut4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rvalid_o(rv[1]), .rdata_o(rdat[1]), .err_o(er[1]),
        .irq_timer_o(irqt[1]), .irq_software_o(irqs[1]));

    always #5 clk_i = ~clk_i;

    // Reference model: time advances by whole ticks derived from cycles since reset.
    int unsigned DIV[2] = '{1, 4};
    int unsigned m_cyc;
    logic [63:0] m_mtime[2];
    logic [63:0] m_cmp[2];
    logic        m_msip[2];
    logic        m_irq[2];
    logic        e_rvalid, e_err;
    logic [31:0] e_rdata[2];

    function automatic logic mapped(logic [15:0] a);
        return a == 16'h0000 || a == 16'h4000 || a == 16'h4004 || a == 16'hBFF8 || a == 16'hBFFC;
    endfunction

    function automatic logic [31:0] model_read(int k, logic [15:0] a);
        case (a)
            16'h0000: return {31'b0, m_msip[k]};
            16'h4000: return m_cmp[k][31:0];
            16'h4004: return m_cmp[k][63:32];
            16'hBFF8: return m_mtime[k][31:0];
            16'hBFFC: return m_mtime[k][63:32];
            default:  return 32'b0;
        endcase
    endfunction

    function automatic logic [63:0] next_mtime(int k);
        logic [63:0] v;
        v = m_mtime[k] + (((m_cyc + 1) % DIV[k] == 0) ? 64'd1 : 64'd0);
        if (req_i && we_i && addr_i == 16'hBFF8) v[31:0] = wdata_i;
        if (req_i && we_i && addr_i == 16'hBFFC) v[63:32] = wdata_i;
        return v;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_cyc    <= 0;
            e_rvalid <= 1'b0;
            e_err    <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_mtime[k] <= '0;
                m_cmp[k]   <= '1;
                m_msip[k]  <= 1'b0;
                m_irq[k]   <= 1'b0;
                e_rdata[k] <= '0;
            end
        end else begin
            m_cyc    <= m_cyc + 1;
            e_rvalid <= req_i;
            e_err    <= req_i && !mapped(addr_i);
            for (int k = 0; k < 2; k++) begin
                m_irq[k]   <= m_mtime[k] >= m_cmp[k];
                m_mtime[k] <= next_mtime(k);
                if (req_i && we_i && addr_i == 16'h4000) m_cmp[k][31:0] <= wdata_i;
                if (req_i && we_i && addr_i == 16'h4004) m_cmp[k][63:32] <= wdata_i;
                if (req_i && we_i && addr_i == 16'h0000) m_msip[k] <= wdata_i[0];
                e_rdata[k] <= (req_i && !we_i && mapped(addr_i)) ? model_read(k, addr_i) : 32'b0;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rvalid[%0d]", k), {31'b0, rv[k]}, {31'b0, e_rvalid});
            chk($sformatf("err[%0d]", k), {31'b0, er[k]}, {31'b0, e_err});
            chk($sformatf("rdata[%0d]", k), rdat[k], e_rdata[k]);
            chk($sformatf("irq_timer[%0d]", k), {31'b0, irqt[k]}, {31'b0, m_irq[k]});
            chk($sformatf("irq_sw[%0d]", k), {31'b0, irqs[k]}, {31'b0, m_msip[k]});
        end
    endtask

    task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        cmp_all();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk_i);
            cmp_all();
        end
    endtask

    task automatic chk_all_zero(string tag);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s[%0d]", tag, k), {28'b0, rv[k], er[k], irqt[k], irqs[k]} | rdat[k], 32'b0);
    endtask

    logic [15:0] addrs[8] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0004, 16'h4002, 16'h0008};
    logic [31:0] r0[2];

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset_outputs");
        rst_n_i = 1'b1;
        idle(3);

        // Timer compare rise and fall
        access(1'b1, 16'hBFF8, 32'h10);
        access(1'b1, 16'hBFFC, 32'h0);
        access(1'b1, 16'h4004, 32'h0);
        access(1'b1, 16'h4000, 32'h14);
        chk("irq_before_match", {31'b0, irqt[0]}, 32'd0);
        idle(1);
        chk("irq_at_match", {31'b0, irqt[0]}, 32'd0);
        idle(1);
        chk("irq_after_match", {31'b0, irqt[0]}, 32'd1);
        access(1'b1, 16'h4000, 32'h1000);
        chk("irq_cmp_raised_lag", {31'b0, irqt[0]}, 32'd1);
        idle(1);
        chk("irq_cmp_raised_fall", {31'b0, irqt[0]}, 32'd0);

        // 64-bit carry
        access(1'b1, 16'hBFF8, 32'hFFFF_FFFE);
        access(1'b1, 16'hBFFC, 32'h7);
        idle(1);
        access(1'b0, 16'hBFFC, 32'h0);
        chk("carry_hi", rdat[0], 32'h8);
        access(1'b0, 16'hBFF8, 32'h0);
        chk("carry_lo", rdat[0], 32'h1);

        // Write beats the tick, then prescaled rate
        access(1'b1, 16'hBFF8, 32'h100);
        access(1'b0, 16'hBFF8, 32'h0);
        chk("write_wins_tick", rdat[0], 32'h100);
        access(1'b0, 16'hBFF8, 32'h0);
        r0[0] = rdat[0]; r0[1] = rdat[1];
        idle(39);
        access(1'b0, 16'hBFF8, 32'h0);
        chk("rate_div1", rdat[0] - r0[0], 32'd40);
        chk("rate_div4", rdat[1] - r0[1], 32'd10);

        // Software interrupt
        access(1'b1, 16'h0000, 32'hFFFF_FFFF);
        chk("msip_set", {31'b0, irqs[0]}, 32'd1);
        access(1'b0, 16'h0000, 32'h0);
        chk("msip_read", rdat[0], 32'h1);
        access(1'b1, 16'h0000, 32'h0);
        chk("msip_clear", {31'b0, irqs[0]}, 32'd0);

        // Bus errors and back-to-back
        access(1'b0, 16'h0004, 32'h0);
        chk("err_unmapped", {30'b0, rv[0], er[0]}, 32'd3);
        chk("err_unmapped_rdata", rdat[0], 32'h0);
        access(1'b0, 16'h4002, 32'h0);
        chk("err_misaligned", {30'b0, rv[0], er[0]}, 32'd3);
        chk("err_misaligned_rdata", rdat[0], 32'h0);
        access(1'b1, 16'h0008, 32'hFFFF_FFFF);
        access(1'b0, 16'h4000, 32'h0);
        chk("ignored_write_cmp", rdat[0], 32'h1000);
        access(1'b0, 16'h0000, 32'h0);
        chk("ignored_write_msip", rdat[0], 32'h0);
        for (int i = 0; i < 8; i++) begin
            access(1'b0, addrs[i], 32'h0);
            chk("b2b_rvalid", {31'b0, rv[0]}, 32'd1);
        end
        idle(1);
        chk("idle_rvalid", {31'b0, rv[0]}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req_i = ($urandom % 4) != 0;
            we_i = $urandom_range(0, 1) == 1;
            addr_i = addrs[$urandom % 8];
            wdata_i = $urandom;
            @(negedge clk_i);
            cmp_all();
        end

        // Reset mid-transaction
        req_i = 1'b1; we_i = 1'b0; addr_i = 16'hBFF8;
        #2 rst_n_i = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk_i);
        chk_all_zero("reset_hold");
        req_i = 1'b0;
        rst_n_i = 1'b1;
        access(1'b0, 16'h4000, 32'h0);
        chk("reset_cmp_lo", rdat[0], 32'hFFFF_FFFF);
        access(1'b0, 16'h4004, 32'h0);
        chk("reset_cmp_hi", rdat[0], 32'hFFFF_FFFF);
        repeat (100) begin
            @(negedge clk_i);
            cmp_all();
            chk("reset_irq_quiet", {30'b0, irqt[1], irqt[0]}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
